// File: rtl/cnn_pkg.sv
// Constants and types shared across the CNN datapath blocks.
package cnn_pkg;

    localparam int IMG_W         = 32;
    localparam int IMG_H         = 32;
    localparam int CONV1_FILTERS = 16;
    localparam int POOL_ADDR_W   = 12;
    localparam int PIX_SAT_MAX   = 255;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } pool_state_e;

endpackage

// File: rtl/pool_line_buf.sv
// Half-row line buffer for 2x2 pooling: synchronous write, asynchronous read.
module pool_line_buf #(
    parameter int DEPTH = 16,
    parameter int DW    = 32,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    // No reset: every entry is written on the even row before the odd row reads it.
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 max-pool with ReLU clamp and 8-bit saturation into feature RAM.
module maxpool2x2_stream
    import cnn_pkg::*;
#(
    parameter int WIDTH   = IMG_W,
    parameter int HEIGHT  = IMG_H,
    parameter int FILTERS = CONV1_FILTERS,
    parameter int IN_W    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [IN_W-1:0]        in_data,
    input  logic                   in_valid,
    output logic                   wr_en,
    output logic [POOL_ADDR_W-1:0] wr_addr,
    output logic [7:0]             wr_data,
    output logic                   done
);

    localparam int HALF_W = WIDTH / 2;
    localparam int PLANE  = (HEIGHT / 2) * HALF_W;
    localparam int CW     = (WIDTH   > 1) ? $clog2(WIDTH)   : 1;
    localparam int RW     = (HEIGHT  > 1) ? $clog2(HEIGHT)  : 1;
    localparam int FW     = (FILTERS > 1) ? $clog2(FILTERS) : 1;
    localparam int LBW    = (HALF_W  > 1) ? $clog2(HALF_W)  : 1;

    pool_state_e            state_q, state_d;
    logic [CW-1:0]          col_q, col_d;
    logic [RW-1:0]          row_q, row_d;
    logic [FW-1:0]          filt_q, filt_d;
    logic [IN_W-1:0]        h_q, h_d;
    logic                   done_q, done_d;
    logic                   wr_en_q, wr_en_d;
    logic [POOL_ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]             wr_data_q, wr_data_d;

    logic                   accept, last_col, last_row, last_filt;
    logic [IN_W-1:0]        samp, lb_rd, hmax;
    logic [LBW-1:0]         lb_idx;
    logic                   lb_we;

    assign accept    = in_valid && (state_q == S_RUN);
    assign samp      = in_data[IN_W-1] ? '0 : in_data;
    assign last_col  = (col_q  == CW'(WIDTH - 1));
    assign last_row  = (row_q  == RW'(HEIGHT - 1));
    assign last_filt = (filt_q == FW'(FILTERS - 1));
    assign lb_idx    = LBW'(col_q >> 1);
    // max(h, sample) serves both the even-row line-buffer write and the final window result
    assign hmax      = (samp > h_q) ? samp : h_q;
    assign lb_we     = accept && !row_q[0] && col_q[0];

    pool_line_buf #(
        .DEPTH (HALF_W),
        .DW    (IN_W),
        .AW    (LBW)
    ) u_lb (
        .clk   (clk),
        .we    (lb_we),
        .waddr (lb_idx),
        .wdata (hmax),
        .raddr (lb_idx),
        .rdata (lb_rd)
    );

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        filt_d    = filt_q;
        h_d       = h_q;
        done_d    = done_q;
        wr_en_d   = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    col_d   = '0;
                    row_d   = '0;
                    filt_d  = '0;
                    done_d  = 1'b0;
                end
            end
            S_RUN: begin
                if (accept) begin
                    case ({row_q[0], col_q[0]})
                        2'b00: h_d = samp;
                        2'b10: h_d = (samp > lb_rd) ? samp : lb_rd;
                        2'b11: begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = POOL_ADDR_W'(filt_q) * POOL_ADDR_W'(PLANE)
                                      + POOL_ADDR_W'(row_q >> 1) * POOL_ADDR_W'(HALF_W)
                                      + POOL_ADDR_W'(col_q >> 1);
                            wr_data_d = (hmax > IN_W'(PIX_SAT_MAX)) ? 8'hFF : hmax[7:0];
                        end
                        default: ;
                    endcase
                    if (last_col) begin
                        col_d = '0;
                        if (last_row) begin
                            row_d  = '0;
                            filt_d = last_filt ? '0 : filt_q + FW'(1);
                        end else begin
                            row_d = row_q + RW'(1);
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                    if (last_col && last_row && last_filt) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            col_q     <= '0;
            row_q     <= '0;
            filt_q    <= '0;
            h_q       <= '0;
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            filt_q    <= filt_d;
            h_q       <= h_d;
            done_q    <= done_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign done    = done_q;

endmodule

// File: doc/maxpool2x2_stream.md
MAXPOOL2X2_STREAM -- requirements
Module: maxpool2x2_stream

Interface
REQ-001 Parameter WIDTH, default 32: conv output columns per feature map; must be even.
REQ-002 Parameter HEIGHT, default 32: conv output rows per feature map; must be even.
REQ-003 Parameter FILTERS, default 16: number of feature maps in the stream.
REQ-004 Parameter IN_W, default 32: input sample width, signed.
REQ-005 Port clk, input, 1: rising-edge clock.
REQ-006 Port rst, input, 1: asynchronous, active-high reset.
REQ-007 Port start, input, 1: one-cycle pulse; arms the block for a new layer.
REQ-008 Port in_data, input, IN_W: conv2d output sample, filter-major, then raster order (row, then column).
REQ-009 Port in_valid, input, 1: in_data is valid this cycle; no backpressure is provided.
REQ-010 Port wr_en, output, 1: feature-RAM write strobe.
REQ-011 Port wr_addr, output, 12: address = f*(HEIGHT/2)*(WIDTH/2) + (row/2)*(WIDTH/2) + col/2.
REQ-012 Port wr_data, output, 8: pooled and saturated value.
REQ-013 Port done, output, 1: level; high from the last write until the next start.

Function
REQ-014 FSM states are S_IDLE, S_RUN and S_DONE; reset enters S_IDLE.
- S_IDLE->S_RUN on start, which clears col, row, filt and done.
- S_RUN->S_DONE on the beat completing sample FILTERS*HEIGHT*WIDTH.
- S_DONE->S_RUN on start.
REQ-015 in_valid is ignored outside S_RUN; start is ignored in S_RUN.
REQ-016 Counters col/row/filt advance only on accepted beats.
- col wraps at WIDTH-1 and increments row.
- row wraps at HEIGHT-1 and increments filt.
REQ-017 Each sample is clamped to 0 if negative (signed compare) before any max operation.
REQ-018 Even row, even col: the clamped sample is latched into the horizontal register h.
REQ-019 Even row, odd col: line buffer entry lb[col/2] is written with max(h, sample).
REQ-020 Odd row, even col: h is set to max(lb[col/2], sample).
REQ-021 Odd row, odd col: result = max(h, sample), and a write is issued.
REQ-022 A write drives wr_en high for exactly one cycle, on the cycle after the accepting beat.
- wr_data = 255 if result > 255, else result[7:0].
- wr_addr follows REQ-011.
REQ-023 Back-to-back in_valid on consecutive cycles is fully supported, at one sample per cycle throughput.
REQ-024 done rises in the same cycle as the final wr_en.
REQ-025 wr_en, wr_addr and wr_data hold 0 when no write is issued.
REQ-026 Maximum comparisons use IN_W-bit unsigned compare after clamping, with no truncation before saturation.

Reset
REQ-027 Asserting rst, including mid-layer, forces the following within the same cycle, asynchronously:
- state to S_IDLE;
- done, wr_en, wr_addr and wr_data to 0;
- col, row, filt and h to 0.
REQ-028 Line buffer contents are not reset; every entry is always written before it is read.
REQ-029 After rst deasserts, no write occurs until a start and a full 2x2 window have been received.

Structure
REQ-030 The shared package cnn_pkg holds the following, and the block imports them:
- constants IMG_W=32, IMG_H=32, CONV1_FILTERS=16;
- POOL_ADDR_W=12;
- PIX_SAT_MAX=255.
REQ-031 The line buffer is the sub-module pool_line_buf: WIDTH/2 x IN_W, one synchronous write port, one asynchronous read port.
REQ-032 The FSM, counters, max logic and saturation reside in maxpool2x2_stream.

Verification
REQ-033 Ramp test: WIDTH=4, HEIGHT=4, FILTERS=1, in_data=0..15.
- Expected writes: (addr0, data 5), (1, 7), (2, 13), (3, 15).
- done is high with the final write.
REQ-034 Saturation/clamp test with window {300, -7, 12, 40}: expect wr_data=255; window {-1, -2, -3, -4}: expect wr_data=0.
REQ-035 Default parameters with 16384 beats, one beat every 2 cycles:
- expect exactly 4096 writes, addresses 0..4095 in order;
- expect done after beat 16384.
REQ-036 Gapped stream test: in_valid randomly idle 0-5 cycles between beats.
- Write data and addresses must be identical to the gap-free run.
- Beats sent in S_DONE produce no writes.
REQ-037 Mid-layer reset test: assert rst after beat 100.
- All outputs must go to 0 immediately.
- A new start followed by a full 16384-beat layer must reproduce the REQ-035 result.
